deshift: RTL and testbench
==========================

// Module: deshift
// PURPOSE
//  Serial-to-parallel capture stage downstream of the parallel-load shift register.
//  - Samples the MSB-first serial stream (sin) one bit per clk, framed by the upstream load strobe (start).
//  - Reassembles a WIDTH-bit word and presents it on a valid/ready output register.
//  - Flags overrun and, optionally, misaligned upstream done timing.
// PARAMETERS
//  WIDTH  32  word length in bits; 2..127; MSB = WIDTH-1
// PORTS
//  clk      in   1        single clock; all state updates on rising edge
//  rst_n    in   1        reset, synchronous, active-low
//  start    in   1        upstream load strobe; high at edge E => sin carries bit MSB during cycle after E
//  sin      in   1        serial data, MSB first, one bit per clk
//  done_in  in   1        upstream done flag; used only when DONE_CHK_EN is defined
//  dout     out  WIDTH    captured word; held stable while dvalid=1
//  dvalid   out  1        word available
//  dready   in   1        consumer accepts word on edge where dvalid&dready
//  busy     out  1        high while in SHIFT or CHECK
//  ovr      out  1        sticky overrun flag
//  ferr     out  1        sticky framing-error flag (DONE_CHK_EN only; else constant 0)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; bit counter=0; dout=0; dvalid=0; busy=0; ovr=0; ferr=0. Reset overrides every other input, mid-frame included; a partial word is discarded.
//  State machine:
//   - IDLE:  start=1 => SHIFT, counter=0.
//   - SHIFT: each edge shifts sin into the capture register LSB, existing bits move left: cap <= {cap[MSB-1:0], sin}; counter += 1.
//     - On the edge where counter==MSB (the WIDTH-th sample, edge E+WIDTH), the word is complete.
//     - Without macro: deliver the word, go to IDLE.
//     - With macro: go to CHECK.
//   - CHECK (macro only): one cycle. Samples done_in at edge E+WIDTH+1, delivers the word, then goes to IDLE.
//  Latency: last bit sampled at E+WIDTH. dvalid is visible after that edge (no macro) or after E+WIDTH+1 (macro).
//  Deliver:
//   - dvalid=0, or dvalid&dready on the same edge: dout<=cap, dvalid<=1.
//   - dvalid=1 and dready=0: new word dropped, dout unchanged, ovr<=1.
//  Handshake: dvalid&dready with no delivery on that edge => dvalid<=0. dout is not cleared.
//  start priority:
//   - start in SHIFT before the final edge: abort, discard partial word, counter=0, stay SHIFT.
//   - start on the final SHIFT edge (no macro), or in CHECK: complete or deliver the current word AND enter SHIFT with counter=0. This supports back-to-back frames.
//   - start in IDLE: SHIFT.
//  busy = (state != IDLE); registered.
//  ovr and ferr: sticky until rst_n=0.
// CONFIGURATION
//  Macro DESHIFT_DONE_CHK_EN:
//   - Defined: CHECK state present. At the CHECK edge, done_in must be 1; if 0, ferr<=1. Word is delivered regardless.
//   - Also defined: done_in=1 sampled during SHIFT => ferr<=1 (premature done).
//   - Undefined: no CHECK state, done_in ignored, ferr tied 0, latency as above.
// TESTING (WIDTH=8)
//  1 rst_n=0 mid-frame (after 3 bits), release, no start => dout=0x00, dvalid=0, busy=0, ovr=0 indefinitely.
//  2 start at E, sin=1,0,1,0,0,1,0,1 at E+1..E+8, dready=0 => dout=0xA5, dvalid=1 after E+8 (E+9 with macro), busy low next cycle.
//  3 word 0xA5 pending, dready=0, second frame 0x3C completes => dout stays 0xA5, ovr=1. Then dready=1 one cycle => dvalid=0.
//  4 start again at E+4 mid-frame, then sin sends 0xFF => only 0xFF delivered, no ovr.
//  5 back-to-back frames 0x81 then 0x7E, start at the final-bit edge (no macro) or CHECK edge (macro), dready=1 => two dvalid words 0x81, 0x7E, no bit lost.
//  6 macro: done_in=0 at CHECK => ferr=1, 0x5A still delivered. done_in=1 at E+3 => ferr=1. Without macro: ferr stays 0.

Source files
------------

// File: rtl/deshift.sv
// deshift: serial-to-parallel capture stage.
// Samples an MSB-first serial stream framed by the upstream load strobe,
// rebuilds a WIDTH-bit word and offers it on a valid/ready output register.
// Sticky overrun flag when a finished word finds the output still occupied.
// Optional feature macro: DESHIFT_DONE_CHK_EN
//   defined   -> adds a one-cycle CHECK state that samples done_in, and
//                flags framing errors (missing done at CHECK, early done in SHIFT)
//   undefined -> no CHECK state, done_in ignored, ferr tied low
module deshift #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sin,
  input  logic             done_in,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  input  logic             dready,
  output logic             busy,
  output logic             ovr,
  output logic             ferr
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;

  logic [WIDTH-1:0] shift_s;
  logic [WIDTH-1:0] word_s;
  logic             deliver_s;
  logic             last_s;

  assign shift_s = {cap_q[WIDTH-2:0], sin};
  assign last_s  = (cnt_q == LAST_CNT);

`ifndef DESHIFT_DONE_CHK_EN
  // done_in has no consumer when the framing check is compiled out.
  logic unused_done_s;
  assign unused_done_s = done_in;
`endif

  // Next-state logic: framing FSM, capture shifter, delivery and sticky flags.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    dout_d    = dout_q;
    dvalid_d  = dvalid_q;
    ovr_d     = ovr_q;
    ferr_d    = ferr_q;
    word_s    = cap_q;
    deliver_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          cnt_d   = {CW{1'b0}};
          cap_d   = {WIDTH{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
`ifdef DESHIFT_DONE_CHK_EN
        // Upstream must not claim done while bits are still arriving.
        if (done_in) begin
          ferr_d = 1'b1;
        end else begin
          ferr_d = ferr_q;
        end
        // A restart strobe always wins here; the word would otherwise
        // swallow the first bit of the next frame during CHECK.
        if (start) begin
          cnt_d = {CW{1'b0}};
          cap_d = {WIDTH{1'b0}};
        end else if (last_s) begin
          cap_d   = shift_s;
          cnt_d   = {CW{1'b0}};
          state_d = ST_CHECK;
        end else begin
          cap_d = shift_s;
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
`else
        if (last_s) begin
          // Final sample: hand the word over; a simultaneous start chains
          // straight into the next frame.
          cap_d     = {WIDTH{1'b0}};
          word_s    = shift_s;
          deliver_s = 1'b1;
          cnt_d     = {CW{1'b0}};
          if (start) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (start) begin
          cnt_d = {CW{1'b0}};
          cap_d = {WIDTH{1'b0}};
        end else begin
          cap_d = shift_s;
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
`endif
      end

`ifdef DESHIFT_DONE_CHK_EN
      ST_CHECK: begin
        // done_in must coincide with this single check cycle.
        if (!done_in) begin
          ferr_d = 1'b1;
        end else begin
          ferr_d = ferr_q;
        end
        word_s    = cap_q;
        deliver_s = 1'b1;
        cnt_d     = {CW{1'b0}};
        cap_d     = {WIDTH{1'b0}};
        if (start) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase

    // Output register: accept a new word only if the slot is free or drains now.
    if (deliver_s) begin
      if (!dvalid_q || dready) begin
        dout_d   = word_s;
        dvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (dvalid_q && dready) begin
      dvalid_d = 1'b0;
    end else begin
      dvalid_d = dvalid_q;
    end

`ifndef DESHIFT_DONE_CHK_EN
    ferr_d = 1'b0;
`endif

    busy_d = (state_d != ST_IDLE);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CW{1'b0}};
      cap_q    <= {WIDTH{1'b0}};
      dout_q   <= {WIDTH{1'b0}};
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign busy   = busy_q;
  assign ovr    = ovr_q;
  assign ferr   = ferr_q;

endmodule

// File: tb/tb_deshift.sv
// tb_deshift: directed frames plus randomized traffic for deshift (WIDTH=8),
// checked every cycle against a word-level behavioural model.
module tb_deshift;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;
`ifdef DESHIFT_DONE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start, sin, done_in, dready;
  logic [W-1:0] dout;
  logic         dvalid, busy, ovr, ferr;

  deshift #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sin(sin), .done_in(done_in),
    .dout(dout), .dvalid(dvalid), .dready(dready), .busy(busy),
    .ovr(ovr), .ferr(ferr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: frame in progress, bits collected so far, word value.
  bit m_active, m_chk, m_dvalid, m_ovr, m_ferr;
  int m_n, m_word, m_dout;

  bit rec_en = 1'b0;
  int got[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit deliver;
    int w;
    deliver = 1'b0;
    w = 0;
    if (!rst_n) begin
      m_active = 1'b0; m_chk = 1'b0; m_n = 0; m_word = 0;
      m_dout = 0; m_dvalid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    end else begin
      if (m_chk) begin
        if (!done_in) m_ferr = 1'b1;
        deliver = 1'b1; w = m_word;
        m_chk = 1'b0; m_active = start; m_n = 0; m_word = 0;
      end else if (m_active) begin
        if (CHK && done_in) m_ferr = 1'b1;
        if (m_n == W - 1 && !(CHK && start)) begin
          w = (m_word * 2 + int'(sin)) & MASK;
          if (CHK) begin
            m_chk = 1'b1; m_active = 1'b0; m_word = w;
          end else begin
            deliver = 1'b1; m_active = start; m_word = 0;
          end
          m_n = 0;
        end else if (start) begin
          m_n = 0; m_word = 0;
        end else begin
          m_word = m_word * 2 + int'(sin); m_n++;
        end
      end else if (start) begin
        m_active = 1'b1; m_n = 0; m_word = 0;
      end
      if (deliver) begin
        if (!m_dvalid || dready) begin
          m_dout = w; m_dvalid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_dvalid && dready) begin
        m_dvalid = 1'b0;
      end
    end
  endtask

  // One clock: advance model with the inputs seen at the edge, then compare.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("dout",   int'(dout),   m_dout);
    chk("dvalid", int'(dvalid), int'(m_dvalid));
    chk("busy",   int'(busy),   int'(m_active || m_chk));
    chk("ovr",    int'(ovr),    int'(m_ovr));
    chk("ferr",   int'(ferr),   int'(m_ferr));
    if (rec_en && dvalid) got.push_back(int'(dout));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0; cycle();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; done_in = 1'b0; cycle();
    rst_n = 1'b1;
  endtask

  task automatic begin_frame();
    start = 1'b1; sin = 1'b0; cycle();
    start = 1'b0;
  endtask

  // Serial bits MSB first; chain=1 raises start where the next frame may begin.
  task automatic send(input int w, input bit chain);
    for (int i = W - 1; i >= 0; i--) begin
      sin   = w[i];
      start = (i == 0) && chain && !CHK;
      cycle();
    end
    start = 1'b0;
    if (chain && CHK) begin
      start = 1'b1; done_in = 1'b1; cycle();
      start = 1'b0; done_in = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sin = 1'b0; done_in = 1'b0; dready = 1'b0;
    idle(3);
    rst_n = 1'b1;
    chk("rst_dout",   int'(dout),   0);
    chk("rst_dvalid", int'(dvalid), 0);
    chk("rst_busy",   int'(busy),   0);

    // Reset in the middle of a frame discards it.
    begin_frame();
    for (int i = 0; i < 3; i++) begin sin = 1'b1; cycle(); end
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    idle(10);
    chk("midrst_dout",   int'(dout),   0);
    chk("midrst_dvalid", int'(dvalid), 0);
    chk("midrst_busy",   int'(busy),   0);
    chk("midrst_ovr",    int'(ovr),    0);

    // Single frame 0xA5 with no consumer.
    do_reset();
    dready = 1'b0;
    begin_frame();
    send(32'hA5, 1'b0);
    if (CHK) idle(1);
    chk("a5_dout",   int'(dout),   32'hA5);
    chk("a5_dvalid", int'(dvalid), 1);
    chk("a5_busy",   int'(busy),   0);

    // Second frame while 0xA5 is still pending: overrun, word kept.
    begin_frame();
    send(32'h3C, 1'b0);
    idle(2);
    chk("ovr_dout", int'(dout), 32'hA5);
    chk("ovr_flag", int'(ovr),  1);
    dready = 1'b1; cycle(); dready = 1'b0;
    chk("drain_dvalid", int'(dvalid), 0);

    // Restart mid-frame: only the restarted word arrives.
    do_reset();
    dready = 1'b0;
    begin_frame();
    for (int i = 0; i < 3; i++) begin sin = 1'b0; cycle(); end
    begin_frame();
    send(32'hFF, 1'b0);
    idle(2);
    chk("abort_dout",   int'(dout),   32'hFF);
    chk("abort_dvalid", int'(dvalid), 1);
    chk("abort_ovr",    int'(ovr),    0);

    // Back-to-back frames with a consumer always ready.
    do_reset();
    dready = 1'b1;
    idle(2);
    got.delete();
    rec_en = 1'b1;
    begin_frame();
    send(32'h81, 1'b1);
    send(32'h7E, 1'b0);
    idle(3);
    rec_en = 1'b0;
    chk("b2b_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("b2b_word0", got[0], 32'h81);
      chk("b2b_word1", got[1], 32'h7E);
    end
    chk("b2b_ovr", int'(ovr), 0);

    // Randomized traffic, including stray done_in and occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 11) == 0);
      sin     = 1'($urandom_range(0, 1));
      dready  = 1'($urandom_range(0, 1));
      done_in = ($urandom_range(0, 3) == 0);
      rst_n   = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst_n = 1'b1; start = 1'b0; done_in = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
